// File: rtl/dp_dm_dmi.sv
// Debug Module DMI register block: dmcontrol/dmstatus/abstractcs/command/data0-1,
// plus a two-state abstract-command engine that accesses the hart register file.
module dp_dm_dmi #(
   parameter int ACK_TIMEOUT = 255
) (
   input  logic        iclk,
   input  logic        iresetn,
   input  logic        dmi_req,
   input  logic [6:0]  dmi_address,
   input  logic [31:0] dmi_wdata,
   input  logic [1:0]  dmi_op,
   output logic [31:0] dmi_rdata,
   output logic        haltreq,
   output logic        resumereq,
   output logic        ndmreset,
   input  logic        halted,
   output logic        reg_req,
   output logic        reg_we,
   output logic [15:0] reg_addr,
   output logic [31:0] reg_wdata,
   input  logic [31:0] reg_rdata,
   input  logic        reg_ack
);

   // Handshakes: a DMI access is a single-cycle strobe (dmi_req) with no back-pressure.
   // reg_req is a level held with stable reg_we/addr/wdata until a one-cycle reg_ack
   // is seen or the timeout expires; an ack outside S_REQ is ignored.
   localparam int CW = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic {S_IDLE, S_REQ} state_t;
   state_t state, state_next;

   logic          dmactive;
   logic [31:0]   data0, data1;
   logic [2:0]    cmderr;
   logic [CW-1:0] cnt;
   logic          busy;

   logic wr, rd, dmctl_wr, cmd_wr, data_acc, active_next;
   logic cmd_bad, cmd_nohalt, cmd_ok, set_err1, timeout_hit;
   logic [31:0] rdata_mux;

   assign wr          = dmi_req && (dmi_op == 2'd2);
   assign rd          = dmi_req && (dmi_op == 2'd1);
   assign dmctl_wr    = wr && (dmi_address == 7'h10);
   assign cmd_wr      = wr && (dmi_address == 7'h17) && dmactive;
   assign data_acc    = (wr || rd) && dmactive && ((dmi_address == 7'h04) || (dmi_address == 7'h05));
   assign active_next = dmctl_wr ? dmi_wdata[0] : dmactive;

   // Command validation in priority order: malformed, then hart not halted, then accept.
   assign cmd_bad     = (dmi_wdata[31:24] != 8'd0) || (dmi_wdata[22:20] != 3'd2);
   assign cmd_nohalt  = !halted && dmi_wdata[17];
   assign cmd_ok      = cmd_wr && !busy && (cmderr == 3'd0) && !cmd_bad && !cmd_nohalt && dmi_wdata[17];
   assign set_err1    = busy && (cmderr == 3'd0) && (data_acc || cmd_wr);
   assign timeout_hit = busy && !reg_ack && (cnt == CW'(ACK_TIMEOUT - 1));

   always_ff @(posedge iclk or negedge iresetn) begin
      if (!iresetn) state <= S_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: if (cmd_ok) state_next = S_REQ;
         S_REQ:  if (reg_ack || timeout_hit) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
      if (!active_next) state_next = S_IDLE;
   end

   always_comb begin
      busy    = (state == S_REQ);
      reg_req = (state == S_REQ);
   end

   always_comb begin
      rdata_mux = 32'd0;
      case (dmi_address)
         7'h04: rdata_mux = busy ? 32'd0 : data0;
         7'h05: rdata_mux = busy ? 32'd0 : data1;
         7'h10: rdata_mux = {haltreq, 28'd0, 1'b0, ndmreset, dmactive};
         7'h11: rdata_mux = {20'd0, ~halted, ~halted, halted, halted, 1'b1, 3'd0, 4'd2};
         7'h16: rdata_mux = {3'd0, 5'd0, 11'd0, busy, 1'b0, cmderr, 4'd0, 4'd2};
         default: rdata_mux = 32'd0;
      endcase
   end

   always_ff @(posedge iclk or negedge iresetn) begin
      if (!iresetn) begin
         dmi_rdata <= 32'd0;
         haltreq   <= 1'b0;
         resumereq <= 1'b0;
         ndmreset  <= 1'b0;
         dmactive  <= 1'b0;
         data0     <= 32'd0;
         data1     <= 32'd0;
         cmderr    <= 3'd0;
         cnt       <= '0;
         reg_we    <= 1'b0;
         reg_addr  <= 16'd0;
         reg_wdata <= 32'd0;
      end else begin
         resumereq <= 1'b0;
         if (rd) dmi_rdata <= rdata_mux;
         if (dmctl_wr) begin
            dmactive  <= dmi_wdata[0];
            ndmreset  <= dmi_wdata[1];
            haltreq   <= dmi_wdata[31];
            resumereq <= dmi_wdata[30] && !dmi_wdata[31];
         end
         if (!active_next) begin
            data0     <= 32'd0;
            data1     <= 32'd0;
            cmderr    <= 3'd0;
            cnt       <= '0;
            reg_we    <= 1'b0;
            reg_addr  <= 16'd0;
            reg_wdata <= 32'd0;
         end else begin
            cnt <= (busy && state_next == S_REQ) ? cnt + CW'(1) : '0;
            if (wr && !busy && dmi_address == 7'h04) data0 <= dmi_wdata;
            if (wr && !busy && dmi_address == 7'h05) data1 <= dmi_wdata;
            if (wr && dmi_address == 7'h16) cmderr <= cmderr & ~dmi_wdata[10:8];
            if (cmd_wr && !busy && cmderr == 3'd0) begin
               if (cmd_bad)         cmderr <= 3'd2;
               else if (cmd_nohalt) cmderr <= 3'd4;
            end
            if (set_err1) cmderr <= 3'd1;
            if (cmd_ok) begin
               reg_we    <= dmi_wdata[16];
               reg_addr  <= dmi_wdata[15:0];
               reg_wdata <= data0;
            end
            // Hart read data takes priority over a colliding DMI write to data0.
            if (busy && reg_ack && !reg_we) data0 <= reg_rdata;
            if (timeout_hit) cmderr <= 3'd3;
         end
      end
   end

endmodule

// File: tb/tb_dp_dm_dmi.sv
// Directed bench for dp_dm_dmi: DMI reads are scored against an expected queue,
// side-band outputs are checked directly with immediate assertions.
module tb_dp_dm_dmi;

   logic        iclk = 1'b0;
   logic        iresetn;
   logic        dmi_req;
   logic [6:0]  dmi_address;
   logic [31:0] dmi_wdata;
   logic [1:0]  dmi_op;
   logic [31:0] dmi_rdata;
   logic        haltreq, resumereq, ndmreset;
   logic        halted;
   logic        reg_req, reg_we;
   logic [15:0] reg_addr;
   logic [31:0] reg_wdata, reg_rdata;
   logic        reg_ack;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   dp_dm_dmi dut (
      .iclk(iclk), .iresetn(iresetn),
      .dmi_req(dmi_req), .dmi_address(dmi_address), .dmi_wdata(dmi_wdata), .dmi_op(dmi_op),
      .dmi_rdata(dmi_rdata), .haltreq(haltreq), .resumereq(resumereq), .ndmreset(ndmreset),
      .halted(halted), .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ack(reg_ack)
   );

   always #5 iclk = ~iclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic dmi_write(input logic [6:0] addr, input logic [31:0] data);
      @(negedge iclk);
      dmi_req = 1'b1; dmi_op = 2'd2; dmi_address = addr; dmi_wdata = data;
      @(negedge iclk);
      dmi_req = 1'b0; dmi_op = 2'd0;
   endtask

   task automatic dmi_read(input string tag, input logic [6:0] addr, input logic [31:0] exp);
      logic [31:0] e;
      exp_q.push_back(exp);
      @(negedge iclk);
      dmi_req = 1'b1; dmi_op = 2'd1; dmi_address = addr;
      @(negedge iclk);
      dmi_req = 1'b0; dmi_op = 2'd0;
      e = exp_q.pop_front();
      check(tag, dmi_rdata, e);
   endtask

   task automatic ack_pulse(input logic [31:0] data);
      @(negedge iclk);
      reg_ack = 1'b1; reg_rdata = data;
      @(negedge iclk);
      reg_ack = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rdata"},  dmi_rdata, 32'd0);
      check({tag, "_halt"},   {31'd0, haltreq}, 32'd0);
      check({tag, "_resume"}, {31'd0, resumereq}, 32'd0);
      check({tag, "_ndm"},    {31'd0, ndmreset}, 32'd0);
      check({tag, "_req"},    {31'd0, reg_req}, 32'd0);
      check({tag, "_we"},     {31'd0, reg_we}, 32'd0);
      check({tag, "_addr"},   {16'd0, reg_addr}, 32'd0);
      check({tag, "_wdata"},  reg_wdata, 32'd0);
   endtask

   initial begin
      int n;
      iresetn = 1'b0; dmi_req = 1'b0; dmi_op = 2'd0; dmi_address = 7'd0; dmi_wdata = 32'd0;
      halted = 1'b0; reg_rdata = 32'd0; reg_ack = 1'b0;
      #1;
      check_reset_outputs("rst0");
      repeat (2) @(negedge iclk);
      iresetn = 1'b1;

      // dmcontrol and dmstatus
      dmi_write(7'h10, 32'h8000_0001);
      check("haltreq_set", {31'd0, haltreq}, 32'd1);
      dmi_read("dmcontrol_rd", 7'h10, 32'h8000_0001);
      halted = 1'b1;
      dmi_read("dmstatus_halted", 7'h11, 32'h0000_0382);
      halted = 1'b0;
      dmi_read("dmstatus_running", 7'h11, 32'h0000_0C82);
      dmi_write(7'h10, 32'h4000_0001);
      check("resume_pulse", {31'd0, resumereq}, 32'd1);
      check("haltreq_clr", {31'd0, haltreq}, 32'd0);
      @(negedge iclk);
      check("resume_one_cycle", {31'd0, resumereq}, 32'd0);
      dmi_write(7'h10, 32'h8000_0001);
      dmi_read("abstractcs_idle", 7'h16, 32'h0000_0002);
      dmi_read("command_reads0", 7'h17, 32'h0000_0000);
      dmi_read("unmapped_reads0", 7'h7F, 32'h0000_0000);

      // data registers and a register write command
      dmi_write(7'h04, 32'hDEAD_BEEF);
      dmi_write(7'h05, 32'h0BAD_F00D);
      dmi_read("data0_rd", 7'h04, 32'hDEAD_BEEF);
      dmi_read("data1_rd", 7'h05, 32'h0BAD_F00D);
      halted = 1'b1;
      dmi_write(7'h17, 32'h0023_1001);
      check("wcmd_req", {31'd0, reg_req}, 32'd1);
      check("wcmd_we", {31'd0, reg_we}, 32'd1);
      check("wcmd_addr", {16'd0, reg_addr}, 32'h0000_1001);
      check("wcmd_wdata", reg_wdata, 32'hDEAD_BEEF);
      @(negedge iclk);
      dmi_read("abstractcs_busy", 7'h16, 32'h0000_1002);
      ack_pulse(32'h0);
      check("wcmd_done_req", {31'd0, reg_req}, 32'd0);
      dmi_read("abstractcs_wdone", 7'h16, 32'h0000_0002);
      dmi_read("data0_after_wcmd", 7'h04, 32'hDEAD_BEEF);

      // register read command
      dmi_write(7'h17, 32'h0022_0005);
      check("rcmd_we", {31'd0, reg_we}, 32'd0);
      check("rcmd_addr", {16'd0, reg_addr}, 32'h0000_0005);
      repeat (2) @(negedge iclk);
      ack_pulse(32'h1234_5678);
      dmi_read("data0_after_rcmd", 7'h04, 32'h1234_5678);

      // command and data access while busy
      dmi_write(7'h17, 32'h0022_0005);
      dmi_write(7'h17, 32'h0022_0005);
      dmi_read("data1_busy_reads0", 7'h05, 32'h0);
      ack_pulse(32'hCAFE_F00D);
      dmi_read("abstractcs_err1", 7'h16, 32'h0000_0102);
      dmi_read("data0_busy_cmd", 7'h04, 32'hCAFE_F00D);
      dmi_write(7'h16, 32'h0000_0700);
      dmi_read("abstractcs_w1c", 7'h16, 32'h0000_0002);

      // ack collides with a DMI write to data0
      dmi_write(7'h17, 32'h0022_0005);
      @(negedge iclk);
      dmi_req = 1'b1; dmi_op = 2'd2; dmi_address = 7'h04; dmi_wdata = 32'h1111_1111;
      reg_ack = 1'b1; reg_rdata = 32'h2222_2222;
      @(negedge iclk);
      dmi_req = 1'b0; dmi_op = 2'd0; reg_ack = 1'b0;
      dmi_read("collide_data0", 7'h04, 32'h2222_2222);
      dmi_read("collide_cmderr", 7'h16, 32'h0000_0102);
      dmi_write(7'h16, 32'h0000_0700);

      // command error classes
      halted = 1'b0;
      dmi_write(7'h17, 32'h0022_0005);
      check("nohalt_noreq", {31'd0, reg_req}, 32'd0);
      dmi_read("abstractcs_err4", 7'h16, 32'h0000_0402);
      dmi_write(7'h16, 32'h0000_0700);
      dmi_write(7'h17, 32'h0032_0005);
      dmi_read("abstractcs_err2", 7'h16, 32'h0000_0202);
      dmi_write(7'h16, 32'h0000_0700);
      dmi_write(7'h17, 32'h0020_0005);
      check("notransfer_noreq", {31'd0, reg_req}, 32'd0);
      dmi_read("abstractcs_notransfer", 7'h16, 32'h0000_0002);

      // ack timeout
      halted = 1'b1;
      dmi_write(7'h17, 32'h0022_0005);
      n = 0;
      while (reg_req && n < 400) begin
         n++;
         @(negedge iclk);
      end
      check("timeout_cycles", n, 32'd255);
      dmi_read("abstractcs_err3", 7'h16, 32'h0000_0302);
      dmi_write(7'h17, 32'h0022_0005);
      check("err_blocks_cmd", {31'd0, reg_req}, 32'd0);
      ack_pulse(32'h5555_5555);
      dmi_read("late_ack_ignored", 7'h04, 32'h2222_2222);
      dmi_read("abstractcs_err3_kept", 7'h16, 32'h0000_0302);
      dmi_write(7'h16, 32'h0000_0700);

      // dmactive=0 aborts and clears
      dmi_write(7'h17, 32'h0022_0005);
      check("abort_start_req", {31'd0, reg_req}, 32'd1);
      dmi_write(7'h10, 32'h0000_0000);
      check("abort_req_low", {31'd0, reg_req}, 32'd0);
      dmi_read("inactive_data0", 7'h04, 32'h0);
      dmi_write(7'h04, 32'h0000_0077);
      dmi_read("inactive_wr_dropped", 7'h04, 32'h0);
      dmi_write(7'h10, 32'h8000_0003);
      check("ndmreset_set", {31'd0, ndmreset}, 32'd1);
      dmi_read("dmcontrol_reenable", 7'h10, 32'h8000_0003);

      // reset in the middle of a command
      dmi_write(7'h04, 32'hA5A5_A5A5);
      dmi_write(7'h17, 32'h0023_1001);
      check("midcmd_req", {31'd0, reg_req}, 32'd1);
      check("midcmd_wdata", reg_wdata, 32'hA5A5_A5A5);
      #2;
      iresetn = 1'b0; reg_ack = 1'b1;
      #1;
      check_reset_outputs("rst_mid");
      @(negedge iclk);
      reg_ack = 1'b0; iresetn = 1'b1;
      @(negedge iclk);
      check("post_rst_req", {31'd0, reg_req}, 32'd0);
      dmi_read("post_rst_dmcontrol", 7'h10, 32'h0);
      dmi_read("post_rst_data0", 7'h04, 32'h0);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
